// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter / fetch sequencer.
// IDLE -> RUN -> DONE under Start/Halt. In RUN it retires one instruction
// per non-stalled cycle. Next PC comes from a plain increment, a branch or
// call target (Jump), or a return address.
// Optional feature macro: CALL_STACK_EN adds a STACK_DEPTH-entry return
// stack and the sticky StackErr flag. Without it, Call is a plain jump,
// Ret is a plain increment, and StackErr is tied low.
module pc_fetch_ctrl #(
    parameter int PC_W        = 12,
    parameter int START_ADDR  = 0,
    parameter int CNT_W       = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    input  logic             Stall,
    input  logic             BranchEn,
    input  logic             Taken,
    input  logic [PC_W-1:0]  Jump,
    input  logic             Call,
    input  logic             Ret,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] InstrCnt,
    output logic             StackErr
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    if (STACK_DEPTH < 1) begin : g_bad_depth
        $error("STACK_DEPTH must be at least 1");
    end

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic [PC_W-1:0]  pc_inc;
    logic [CNT_W-1:0] cnt_sat;

`ifdef CALL_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [STACK_DEPTH-1:0][PC_W-1:0] stack_q, stack_d;
    logic [SP_W-1:0]                  sp_q, sp_d;
    logic [SP_W-1:0]                  sp_m1;
    logic                             err_q, err_d;

    assign sp_m1    = sp_q - SP_W'(1);
    assign StackErr = err_q;
`else
    assign StackErr = 1'b0;
`endif

    assign pc_inc  = pc_q + 1'b1;
    // Retired count sticks at all-ones instead of wrapping.
    assign cnt_sat = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    // Next-state, next-PC and counter selection; one RUN action per cycle.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
`ifdef CALL_STACK_EN
        sp_d    = sp_q;
        stack_d = stack_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_RUN: begin
                if (!Stall) begin
                    cnt_d = cnt_sat;
                    if (Halt) begin
                        state_d = S_DONE;
                    end else if (Ret) begin
`ifdef CALL_STACK_EN
                        if (sp_q == '0) begin
                            err_d = 1'b1;
                            pc_d  = pc_inc;
                        end else begin
                            pc_d = stack_q[sp_m1[IDX_W-1:0]];
                            sp_d = sp_m1;
                        end
`else
                        pc_d = pc_inc;
`endif
                    end else if (Call) begin
`ifdef CALL_STACK_EN
                        // A full stack drops the push but the call still jumps.
                        if (sp_q == SP_W'(STACK_DEPTH)) begin
                            err_d = 1'b1;
                        end else begin
                            stack_d[sp_q[IDX_W-1:0]] = pc_inc;
                            sp_d = sp_q + SP_W'(1);
                        end
`endif
                        pc_d = Jump;
                    end else if (BranchEn && Taken) begin
                        pc_d = Jump;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            default: begin
                // IDLE and DONE both wait for Start and reload the same way.
                if (Start) begin
                    state_d = S_RUN;
                    pc_d    = PC_W'(START_ADDR);
                    cnt_d   = '0;
`ifdef CALL_STACK_EN
                    sp_d    = '0;
                    err_d   = 1'b0;
`endif
                end
            end
        endcase
        running_d = (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
    end

    // State and output registers; synchronous reset dominates all inputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            pc_q      <= PC_W'(START_ADDR);
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef CALL_STACK_EN
            sp_q      <= '0;
            stack_q   <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
            done_q    <= done_d;
`ifdef CALL_STACK_EN
            sp_q      <= sp_d;
            stack_q   <= stack_d;
            err_q     <= err_d;
`endif
        end
    end

    assign ProgCtr  = pc_q;
    assign Running  = running_q;
    assign Done     = done_q;
    assign InstrCnt = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed scenarios plus randomized traffic, all checked
// each cycle against a queue-based behavioural model of the sequencer.
// A narrow counter is used so that saturation is reached during the run.
module tb_pc_fetch_ctrl;

    localparam int PC_W  = 12;
    localparam int CNT_W = 5;
    localparam int DEPTH = 4;
    localparam int PC_MOD = 1 << PC_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             Clk = 1'b0;
    logic             Reset, Start, Halt, Stall, BranchEn, Taken, Call, Ret;
    logic [PC_W-1:0]  Jump;
    logic [PC_W-1:0]  ProgCtr;
    logic             Running, Done, StackErr;
    logic [CNT_W-1:0] InstrCnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode is "idle", "run" or "done".
    string m_mode = "idle";
    int    m_pc   = 0;
    int    m_cnt  = 0;
    bit    m_err  = 1'b0;
    int    m_stk[$];

    pc_fetch_ctrl #(.PC_W(PC_W), .START_ADDR(0), .CNT_W(CNT_W), .STACK_DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Stall(Stall),
        .BranchEn(BranchEn), .Taken(Taken), .Jump(Jump), .Call(Call), .Ret(Ret),
        .ProgCtr(ProgCtr), .Running(Running), .Done(Done), .InstrCnt(InstrCnt),
        .StackErr(StackErr)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clr_in();
        Reset = 0; Start = 0; Halt = 0; Stall = 0;
        BranchEn = 0; Taken = 0; Call = 0; Ret = 0; Jump = '0;
    endtask

    function automatic int retire(input int c);
        return (c < CNT_MAX) ? c + 1 : c;
    endfunction

    task automatic model_edge();
        if (Reset) begin
            m_mode = "idle"; m_pc = 0; m_cnt = 0; m_err = 0; m_stk.delete();
        end else if (m_mode != "run") begin
            if (Start) begin
                m_mode = "run"; m_pc = 0; m_cnt = 0; m_err = 0; m_stk.delete();
            end
        end else if (!Stall) begin
            m_cnt = retire(m_cnt);
            if (Halt) m_mode = "done";
`ifdef CALL_STACK_EN
            else if (Ret) begin
                if (m_stk.size() == 0) begin m_err = 1; m_pc = (m_pc + 1) % PC_MOD; end
                else m_pc = m_stk.pop_back();
            end else if (Call) begin
                if (m_stk.size() == DEPTH) m_err = 1;
                else m_stk.push_back((m_pc + 1) % PC_MOD);
                m_pc = int'(Jump);
            end
`else
            else if (Ret) m_pc = (m_pc + 1) % PC_MOD;
            else if (Call) m_pc = int'(Jump);
`endif
            else if (BranchEn && Taken) m_pc = int'(Jump);
            else m_pc = (m_pc + 1) % PC_MOD;
        end
    endtask

    // One clock: update model at the edge, compare 1 ns later, return at negedge.
    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
        chk("pc", 32'(ProgCtr), 32'(m_pc));
        chk("cnt", 32'(InstrCnt), 32'(m_cnt));
        chk("running", 32'(Running), 32'(m_mode == "run"));
        chk("done", 32'(Done), 32'(m_mode == "done"));
        chk("stackerr", 32'(StackErr), 32'(m_err));
        @(negedge Clk);
    endtask

    task automatic restart_to(input int n);
        clr_in(); Reset = 1; step();
        Reset = 0; Start = 1; step();
        Start = 0;
        repeat (n) step();
    endtask

    initial begin
        clr_in();
        @(negedge Clk);
        Reset = 1; step(); Reset = 0;
        chk("rst_pc", 32'(ProgCtr), 0);
        chk("rst_running", 32'(Running), 0);
        chk("rst_done", 32'(Done), 0);
        chk("rst_cnt", 32'(InstrCnt), 0);
        step();
        chk("idle_hold_pc", 32'(ProgCtr), 0);

        // T1: plain sequencing
        restart_to(5);
        chk("t1_pc", 32'(ProgCtr), 5);
        chk("t1_cnt", 32'(InstrCnt), 5);
        chk("t1_running", 32'(Running), 1);

        // T2: taken / not-taken branch at PC=3
        restart_to(3);
        BranchEn = 1; Taken = 1; Jump = 12'd74; step();
        chk("t2_taken", 32'(ProgCtr), 74);
        restart_to(3);
        BranchEn = 1; Taken = 0; Jump = 12'd74; step();
        chk("t2_nottaken", 32'(ProgCtr), 4);

        // T3: stall, halt, restart from DONE; Start in RUN ignored
        restart_to(10);
        Stall = 1; Start = 1; repeat (3) step();
        chk("t3_stall_pc", 32'(ProgCtr), 10);
        chk("t3_stall_cnt", 32'(InstrCnt), 10);
        clr_in(); repeat (2) step();
        Halt = 1; step(); Halt = 0;
        chk("t3_halt_done", 32'(Done), 1);
        chk("t3_halt_run", 32'(Running), 0);
        chk("t3_halt_pc", 32'(ProgCtr), 12);
        step();
        chk("t3_done_hold", 32'(Done), 1);
        Start = 1; step(); Start = 0;
        chk("t3_start_pc", 32'(ProgCtr), 0);
        chk("t3_start_done", 32'(Done), 0);
        chk("t3_start_cnt", 32'(InstrCnt), 0);

        // T4: wrap and Reset+Start
        restart_to(0);
        BranchEn = 1; Taken = 1; Jump = 12'd4095; step();
        chk("t4_jmp", 32'(ProgCtr), 4095);
        clr_in(); step();
        chk("t4_wrap", 32'(ProgCtr), 0);
        restart_to(80);
        chk("t4_cnt_sat", 32'(InstrCnt), CNT_MAX);
        Reset = 1; Start = 1; step(); clr_in();
        chk("t4_rst_pc", 32'(ProgCtr), 0);
        chk("t4_rst_done", 32'(Done), 0);
        chk("t4_rst_run", 32'(Running), 0);

`ifdef CALL_STACK_EN
        // T5: return stack, overflow and underflow
        restart_to(5);
        Call = 1; Jump = 12'd57; step(); clr_in();
        chk("t5_call", 32'(ProgCtr), 57);
        Ret = 1; Call = 1; Jump = 12'd99; step(); clr_in();
        chk("t5_ret", 32'(ProgCtr), 6);
        for (int i = 0; i < 5; i++) begin
            Call = 1; Jump = 12'(100 + i * 10); step();
            chk("t5_err_nest", 32'(StackErr), (i == 4) ? 1 : 0);
        end
        restart_to(20);
        Ret = 1; step(); clr_in();
        chk("t5_uf_pc", 32'(ProgCtr), 21);
        chk("t5_uf_err", 32'(StackErr), 1);
`else
        // T6: call/ret without stack
        restart_to(5);
        Call = 1; Jump = 12'd57; step(); clr_in();
        chk("t6_call", 32'(ProgCtr), 57);
        Ret = 1; step(); clr_in();
        chk("t6_ret", 32'(ProgCtr), 58);
        chk("t6_err", 32'(StackErr), 0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            Reset    = ($urandom_range(0, 199) == 0);
            Start    = ($urandom_range(0, 7) == 0);
            Halt     = ($urandom_range(0, 24) == 0);
            Stall    = ($urandom_range(0, 5) == 0);
            BranchEn = ($urandom_range(0, 2) == 0);
            Taken    = $urandom_range(0, 1) == 1;
            Call     = ($urandom_range(0, 6) == 0);
            Ret      = ($urandom_range(0, 6) == 0);
            Jump     = PC_W'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
